// File: rtl/round_timer_ctrl_pkg.sv
// Shared types and constants for the round countdown controller.
package round_pkg;

  // Round lifecycle states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSED  = 3'd2,
    WON     = 3'd3,
    EXPIRED = 3'd4
  } round_state_t;

  // Width of the seconds value produced by secs_for (holds up to 90).
  localparam int SECS_W = 7;

  localparam logic [SECS_W-1:0] SECS_EASY = 7'd30;
  localparam logic [SECS_W-1:0] SECS_MED  = 7'd60;
  localparam logic [SECS_W-1:0] SECS_HARD = 7'd90;

  // Time budget for a difficulty code; 0 marks an invalid difficulty.
  function automatic logic [SECS_W-1:0] secs_for(input logic [1:0] max_digit);
    logic [SECS_W-1:0] secs;
    case (max_digit)
      2'd1:    secs = SECS_EASY;
      2'd2:    secs = SECS_MED;
      2'd3:    secs = SECS_HARD;
      default: secs = '0;
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/round_timer_ctrl_sec_tick_gen.sv
// One-second prescaler: counts enabled cycles and emits a single-cycle
// tick on the cycle where the count wraps. The count holds while disabled,
// so a paused countdown resumes mid-period instead of restarting.
module sec_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic restart,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] cnt_reg;
  logic [PW-1:0] cnt_next;

  // Next count: clear on load, advance and wrap only while enabled.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + PW'(1);
    end
  end

  // Count register with active-low synchronous restart.
  always_ff @(posedge clk) begin
    if (!restart) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Tick is combinational so the countdown applies it on the wrap edge.
  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: loads the difficulty budget, decrements once
// per second while running, and arbitrates win versus timeout. time_left is
// the authoritative remaining-time value; win/timeout are registered pulses.
module round_timer_ctrl
  import round_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int CW          = 7
) (
  input  logic          clk,
  input  logic          restart,
  input  logic          start,
  input  logic [1:0]    max_digit,
  input  logic          pause,
  input  logic          guess_valid,
  input  logic          guess_correct,
  output logic [CW-1:0] time_left,
  output logic          running,
  output logic          win,
  output logic          timeout,
  output logic          done
);

  round_state_t  state_reg;
  round_state_t  state_next;
  logic [CW-1:0] time_left_reg;
  logic [CW-1:0] time_left_next;
  logic          win_reg;
  logic          win_next;
  logic          timeout_reg;
  logic          timeout_next;

  logic          tick;
  logic          tick_en;
  logic          tick_clr;
  logic          start_ok;
  logic          can_load;
  logic          guess_hit;
  logic [CW-1:0] load_secs;

  assign load_secs = CW'(secs_for(max_digit));
  assign start_ok  = start && (max_digit != 2'd0);
  assign can_load  = (state_reg == IDLE) || (state_reg == WON) || (state_reg == EXPIRED);
  assign guess_hit = guess_valid && guess_correct;

  // The prescaler only advances in RUN and restarts its period on every load.
  assign tick_en  = (state_reg == RUN);
  assign tick_clr = can_load && start_ok;

  sec_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_sec_tick_gen (
    .clk    (clk),
    .restart(restart),
    .en     (tick_en),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // Next-state, countdown and outcome-event logic; a correct guess beats a tick.
  always_comb begin
    state_next     = state_reg;
    time_left_next = time_left_reg;
    win_next       = 1'b0;
    timeout_next   = 1'b0;

    case (state_reg)
      IDLE, WON, EXPIRED: begin
        if (start_ok) begin
          state_next     = RUN;
          time_left_next = load_secs;
        end
      end

      RUN: begin
        if (guess_hit) begin
          state_next = WON;
          win_next   = 1'b1;
        end else begin
          if (tick) begin
            if (time_left_reg > CW'(1)) begin
              time_left_next = time_left_reg - CW'(1);
            end else begin
              time_left_next = '0;
              state_next     = EXPIRED;
              timeout_next   = 1'b1;
            end
          end
          // Pause still lets a coincident tick land; expiry takes precedence.
          if (pause && (state_next == RUN)) begin
            state_next = PAUSED;
          end
        end
      end

      PAUSED: begin
        if (guess_hit) begin
          state_next = WON;
          win_next   = 1'b1;
        end else if (!pause) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next     = IDLE;
        time_left_next = '0;
      end
    endcase
  end

  // State, countdown and event registers with active-low synchronous restart.
  always_ff @(posedge clk) begin
    if (!restart) begin
      state_reg     <= IDLE;
      time_left_reg <= '0;
      win_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      time_left_reg <= time_left_next;
      win_reg       <= win_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign time_left = time_left_reg;
  assign running   = (state_reg == RUN) || (state_reg == PAUSED);
  assign done      = (state_reg == WON) || (state_reg == EXPIRED);
  assign win       = win_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl with TICK_CYCLES=4. The stimulus
// process runs a behavioural model of the round rules and queues the
// expected outputs; a negedge monitor pops and compares them.
module tb_round_timer_ctrl;

  localparam int TICK = 4;
  localparam int CW   = 7;

  logic          clk = 1'b0;
  logic          restart = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    max_digit = 2'd0;
  logic          pause = 1'b0;
  logic          guess_valid = 1'b0;
  logic          guess_correct = 1'b0;
  logic [CW-1:0] time_left;
  logic          running;
  logic          win;
  logic          timeout;
  logic          done;

  always #5 clk = ~clk;

  round_timer_ctrl #(
    .TICK_CYCLES(TICK),
    .CW         (CW)
  ) dut (
    .clk          (clk),
    .restart      (restart),
    .start        (start),
    .max_digit    (max_digit),
    .pause        (pause),
    .guess_valid  (guess_valid),
    .guess_correct(guess_correct),
    .time_left    (time_left),
    .running      (running),
    .win          (win),
    .timeout      (timeout),
    .done         (done)
  );

  typedef struct {
    int tl;
    bit run;
    bit dn;
    bit w;
    bit t;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_WON, M_EXPIRED} mode_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  mode_t m_mode = M_IDLE;
  int    m_secs = 0;
  int    m_phase = 0;   // cycles already counted in the current second
  bit    pz_lvl = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Behavioural round rules: seconds budget 30*difficulty, one second per TICK cycles.
  task automatic model(input bit rn, input bit st, input bit [1:0] md,
                       input bit pz, input bit gv, input bit gc, output exp_t e);
    bit sec_done;
    e.w = 1'b0;
    e.t = 1'b0;
    if (!rn) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_WON, M_EXPIRED: begin
          if (st && md != 0) begin
            m_secs = 30 * int'(md); m_phase = 0; m_mode = M_RUN;
          end
        end
        M_RUN: begin
          sec_done = (m_phase == TICK - 1);
          m_phase  = (m_phase + 1) % TICK;
          if (gv && gc) begin
            m_mode = M_WON; e.w = 1'b1;
          end else begin
            if (sec_done) begin
              if (m_secs > 1) m_secs = m_secs - 1;
              else begin m_secs = 0; m_mode = M_EXPIRED; e.t = 1'b1; end
            end
            if (pz && m_mode == M_RUN) m_mode = M_PAUSED;
          end
        end
        M_PAUSED: begin
          if (gv && gc) begin m_mode = M_WON; e.w = 1'b1; end
          else if (!pz) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    e.tl  = m_secs;
    e.run = (m_mode == M_RUN) || (m_mode == M_PAUSED);
    e.dn  = (m_mode == M_WON) || (m_mode == M_EXPIRED);
  endtask

  // Drive one cycle of inputs, then queue the expectation for after the edge.
  task automatic step(input bit rn, input bit st, input bit [1:0] md,
                      input bit pz, input bit gv, input bit gc);
    exp_t e;
    restart = rn; start = st; max_digit = md; pause = pz;
    guess_valid = gv; guess_correct = gc;
    model(rn, st, md, pz, gv, gc, e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, pz_lvl, 1'b0, 1'b0);
  endtask

  // Run until the model reaches a given second (optionally its tick cycle).
  task automatic run_until(input int target, input bit at_tick, input string name);
    int n = 0;
    while (!(m_secs == target && (!at_tick || m_phase == TICK - 1)) && n < 1000) begin
      step(1'b1, 1'b0, 2'd0, pz_lvl, 1'b0, 1'b0);
      n++;
    end
    if (n >= 1000) begin
      bad++;
      $display("FAIL %s wait bound expired actual=%0d required=%0d", name, m_secs, target);
    end
  endtask

  // Monitor: compare every DUT output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("time_left", int'(time_left), e.tl);
      chk("running",   int'(running),   int'(e.run));
      chk("done",      int'(done),      int'(e.dn));
      chk("win",       int'(win),       int'(e.w));
      chk("timeout",   int'(timeout),   int'(e.t));
      if (e.w || e.t)
        $display("event t=%0t %s time_left=%0d", $time, e.w ? "win" : "timeout", time_left);
    end
  end

  initial begin
    #1;
    // 1: reset, then invalid start stays idle
    $display("scenario 1: reset and invalid start");
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // 2: easy round runs out
    $display("scenario 2: easy round expires");
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    idle(126);

    // 3: hard round won at 17 s
    $display("scenario 3: win at 17");
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    run_until(17, 1'b0, "reach17");
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(24);

    // 4: correct guess coincides with the final tick
    $display("scenario 4: win beats expiry");
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    run_until(1, 1'b1, "last_tick");
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idle(6);

    // 5: pause two cycles into a period, hold, release; then win while paused
    $display("scenario 5: pause mid-period");
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    idle(3);

    // 6: start in RUN ignored, wrong guess ignored, restart mid-round
    $display("scenario 6: ignored inputs and mid-round restart");
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    run_until(45, 1'b0, "reach45");
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomised traffic
    $display("scenario 7: random traffic");
    for (int i = 0; i < 1500; i++) begin
      bit rn, st, gv, gc;
      bit [1:0] md;
      rn = ($urandom % 200) != 0;
      st = ($urandom % 20) == 0;
      md = 2'($urandom % 4);
      if (($urandom % 12) == 0) pz_lvl = ~pz_lvl;
      gv = ($urandom % 40) == 0;
      gc = ($urandom % 2) == 1;
      step(rn, st, md, pz_lvl, gv, gc);
    end
    pz_lvl = 1'b0;
    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
